// File: rtl/l1a_sched_pkg.sv
// Shared types and constants for the L1A readout scheduler: FSM states, queued entry layout,
// watchdog limit and saturating-counter helper.
package l1a_sched_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

   localparam int L1N_W_DEF = 12;

   typedef struct packed {
      logic                 match;
      logic [L1N_W_DEF-1:0] l1n;
   } entry_t;

   localparam int         TMO_CYC  = 4095;
   localparam logic [7:0] OVFL_MAX = 8'd255;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == OVFL_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/l1a_readout_sched_fifo.sv
// First-word-fall-through FIFO: head is combinational, a push shows at the head and in count
// one cycle later; push while full is accepted only together with a pop.
module sched_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 13
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & ~empty_q;
      do_push  = push & (~full_q | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      full_d   = (count_d == (AW+1)'(DEPTH));
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset: nothing is read while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;

endmodule

// File: rtl/l1a_readout_sched.sv
// Queues GMATCH/NO_MATCH decisions with their L1A number and issues them one at a time to the
// readout engine (RD_START 2 cycles after a decision when idle). Watchdog: L1A_SCHED_TIMEOUT_EN.
module l1a_readout_sched
   import l1a_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int L1N_W = L1N_W_DEF,
   parameter int GAP   = 2,
   parameter int TMR   = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   GMATCH,
   input  logic                   NO_MATCH,
   input  logic                   L1N_RST,
   input  logic                   RD_BUSY,
   input  logic                   RD_DONE,
   output logic                   RD_START,
   output logic                   RD_MATCH,
   output logic [L1N_W-1:0]       RD_L1N,
   output logic                   FIFO_EMPTY,
   output logic                   FIFO_FULL,
   output logic [$clog2(DEPTH):0] PEND,
   output logic [7:0]             OVFL_CNT,
   output logic                   ACTIVE
`ifdef L1A_SCHED_TIMEOUT_EN
   ,
   output logic                   RD_TMO,
   output logic [7:0]             TMO_CNT
`endif
);
   localparam int         CW        = $clog2(DEPTH) + 1;
   localparam logic [3:0] GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam state_t     POST_WAIT = state_t'((GAP > 0) ? S_GAP : S_IDLE);

   if (L1N_W != L1N_W_DEF) begin : g_bad_l1n_w
      $error("L1N_W must match the entry layout in l1a_sched_pkg");
   end
   if (TMR != 0) begin : g_tmr
   end

   state_t           state_q;
   entry_t           push_ent, head_ent;
   logic             dec, pop;
   logic             ff_full, ff_empty;
   logic [CW-1:0]    ff_count;
   logic [L1N_W-1:0] l1n_q, l1n_d;
   logic [7:0]       ovfl_q, ovfl_d;
   logic             rd_start_q, rd_match_q, active_q;
   logic [L1N_W-1:0] rd_l1n_q;
   logic [3:0]       gap_cnt_q;
`ifdef L1A_SCHED_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
   logic [15:0]      wd_q;
   logic             rd_tmo_q;
   logic [7:0]       tmo_cnt_q;
`endif

   // A dropped decision still consumes an L1A number so numbering tracks the L1A count.
   always_comb begin
      dec      = GMATCH | NO_MATCH;
      pop      = (state_q == S_ISSUE);
      push_ent = '{match: GMATCH, l1n: l1n_q};
      l1n_d    = l1n_q;
      if (L1N_RST)  l1n_d = '0;
      else if (dec) l1n_d = l1n_q + L1N_W'(1);
      ovfl_d = ovfl_q;
      if (dec & ff_full & ~pop) ovfl_d = sat_inc8(ovfl_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         l1n_q  <= '0;
         ovfl_q <= '0;
      end else begin
         l1n_q  <= l1n_d;
         ovfl_q <= ovfl_d;
      end
   end

   sched_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push     (dec),
      .push_dat (push_ent),
      .pop      (pop),
      .head_dat (head_ent),
      .count    (ff_count),
      .full     (ff_full),
      .empty    (ff_empty)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         rd_start_q <= 1'b0;
         rd_match_q <= 1'b0;
         rd_l1n_q   <= '0;
         active_q   <= 1'b0;
         gap_cnt_q  <= '0;
`ifdef L1A_SCHED_TIMEOUT_EN
         wd_q       <= '0;
         rd_tmo_q   <= 1'b0;
         tmo_cnt_q  <= '0;
`endif
      end else begin
         rd_start_q <= 1'b0;
`ifdef L1A_SCHED_TIMEOUT_EN
         rd_tmo_q   <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (~ff_empty & ~RD_BUSY) begin
                  state_q    <= S_ISSUE;
                  rd_start_q <= 1'b1;
                  rd_match_q <= head_ent.match;
                  rd_l1n_q   <= head_ent.l1n;
                  active_q   <= 1'b1;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
`ifdef L1A_SCHED_TIMEOUT_EN
               wd_q    <= '0;
`endif
            end
            S_WAIT: begin
               if (RD_DONE) begin
                  state_q   <= POST_WAIT;
                  active_q  <= 1'b0;
                  gap_cnt_q <= '0;
               end
`ifdef L1A_SCHED_TIMEOUT_EN
               else if (wd_q == TMO_LAST) begin
                  state_q   <= POST_WAIT;
                  active_q  <= 1'b0;
                  gap_cnt_q <= '0;
                  rd_tmo_q  <= 1'b1;
                  tmo_cnt_q <= sat_inc8(tmo_cnt_q);
               end else begin
                  wd_q <= wd_q + 16'd1;
               end
`endif
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) state_q <= S_IDLE;
               else                       gap_cnt_q <= gap_cnt_q + 4'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign RD_START   = rd_start_q;
   assign RD_MATCH   = rd_match_q;
   assign RD_L1N     = rd_l1n_q;
   assign FIFO_EMPTY = ff_empty;
   assign FIFO_FULL  = ff_full;
   assign PEND       = ff_count;
   assign OVFL_CNT   = ovfl_q;
   assign ACTIVE     = active_q;
`ifdef L1A_SCHED_TIMEOUT_EN
   assign RD_TMO     = rd_tmo_q;
   assign TMO_CNT    = tmo_cnt_q;
`endif

endmodule

// File: doc/l1a_readout_sched.md
Name: l1a_readout_sched

Overview:
- Schedules readout of trigger decisions coming from the trigger-match register (GMATCH = matched L1A, NO_MATCH = unmatched L1A).
- Each decision is queued with its L1A number in a small FIFO. Entries are issued one at a time to the downstream readout engine over a start/busy/done handshake.
- The block sits between the trigger-match register and the DCFEB/CFEB readout engine. It absorbs back-to-back L1As while the engine is busy.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, 2..32.
- L1N_W, 12: width of the L1A event number.
- GAP, 2: idle cycles enforced after RD_DONE before the next RD_START; 0..15.
- TMR, 0: passed to counters for triple-modular-redundancy builds; no functional effect.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- GMATCH  in  1  one-cycle pulse: L1A matched an LCT.
- NO_MATCH  in  1  one-cycle pulse: L1A without a matching LCT.
- L1N_RST  in  1  synchronous clear of the L1A number counter (resync).
- RD_BUSY  in  1  readout engine busy.
- RD_DONE  in  1  one-cycle pulse: engine finished the current event.
- RD_START  out  1  one-cycle pulse: start readout of the head entry.
- RD_MATCH  out  1  head entry type (1 = full readout, 0 = header-only); valid with RD_START, held until the next RD_START.
- RD_L1N  out  L1N_W  L1A number of the issued entry; same validity as RD_MATCH.
- FIFO_EMPTY  out  1  no pending entries.
- FIFO_FULL  out  1  DEPTH entries pending.
- PEND  out  $clog2(DEPTH)+1  count of pending entries.
- OVFL_CNT  out  8  saturating count of dropped decisions.
- ACTIVE  out  1  high from RD_START through RD_DONE, inclusive.

Behaviour:
- Reset: all registered outputs are 0 except FIFO_EMPTY = 1. Also cleared: FIFO pointers, L1A counter, OVFL_CNT; FSM goes to IDLE.
- Reset mid-operation discards the queue and the in-flight event. The engine is not notified.
- Decision capture:
  - dec = GMATCH | NO_MATCH; type = GMATCH. If both pulse in the same cycle, GMATCH wins and only one entry is pushed.
  - Each dec pushes {type, l1n} and then increments l1n. l1n wraps modulo 2^L1N_W.
  - The first decision after reset or L1N_RST carries l1n = 0.
  - L1N_RST in the same cycle as dec: the entry gets the pre-clear value, and l1n becomes 0 (not 1).
- Overflow:
  - A dec while FIFO_FULL, with no pop in the same cycle, is dropped. OVFL_CNT increments and saturates at 255. l1n still increments, so numbering stays aligned with the L1A count.
  - A dec while full, with a pop in the same cycle, is accepted; PEND stays at DEPTH.
- FIFO: first-word-fall-through (FWFT). The head is visible combinationally to the FSM. A push is visible at the head one cycle later. PEND reflects the push/pop one cycle after it.
- FSM states:
  - IDLE: go to ISSUE if !FIFO_EMPTY & !RD_BUSY.
  - ISSUE:
    - Assert RD_START for 1 cycle.
    - Register RD_MATCH/RD_L1N from the head.
    - Pop.
    - Go to WAIT.
  - WAIT: ACTIVE = 1; on RD_DONE go to GAP, or to IDLE if GAP = 0.
  - GAP: count GAP cycles, then go to IDLE.
- Latency and issue rate:
  - A decision into an empty, idle block gives RD_START 2 cycles after the dec cycle.
  - Minimum RD_START spacing is 3 + GAP cycles: ISSUE, WAIT(done) → GAP×GAP → IDLE → ISSUE.
- RD_BUSY is sampled only in IDLE. RD_DONE outside WAIT is ignored.

Optional Feature:
- Macro: L1A_SCHED_TIMEOUT_EN.
- When defined:
  - Add a 16-bit watchdog in WAIT. If it reaches TMO_CYC (localparam 4095) without RD_DONE, the FSM goes to GAP.
  - Add output RD_TMO, a 1-cycle pulse, and output TMO_CNT[7:0], a saturating count of timeouts.
- When undefined: WAIT waits indefinitely; RD_TMO and TMO_CNT are not present.

Decomposition:
- Shared package l1a_sched_pkg:
  - FSM state enum {IDLE, ISSUE, WAIT, GAP}.
  - Entry struct {match, l1n}.
  - TMO_CYC constant.
  - OVFL_MAX = 255.
- One sub-module, sched_fifo: synchronous FWFT FIFO with parameters DEPTH and WIDTH, a count output, and full/empty flags. It supports simultaneous push/pop when full.
- The FSM, the L1A counter and the counters stay in the top module.

Test Plan:
- Single GMATCH after reset, RD_BUSY = 0:
  - RD_START 2 cycles later with RD_MATCH = 1, RD_L1N = 0.
  - RD_DONE 5 cycles later, then next IDLE after GAP = 2.
- GMATCH and NO_MATCH in the same cycle, then NO_MATCH alone:
  - Two entries are issued: (1, 0) and (0, 1).
- 10 back-to-back decisions while the engine is held busy (DEPTH = 8):
  - FIFO_FULL asserts.
  - OVFL_CNT = 2.
  - Issued L1A numbers are 0..7; numbers 8 and 9 are never issued.
- L1N_RST coincident with the 3rd decision:
  - Entries are numbered 0, 1, 2; the 4th decision carries number 0.
- RST asserted in WAIT with 3 entries pending:
  - Next cycle: FIFO_EMPTY = 1, PEND = 0, ACTIVE = 0, OVFL_CNT = 0.
  - A late RD_DONE is ignored.
- With L1A_SCHED_TIMEOUT_EN defined, RD_DONE withheld:
  - RD_TMO pulses 4095 cycles after entering WAIT.
  - TMO_CNT = 1.
  - The next pending entry is issued after GAP.
